bus_arb_rr: RTL and testbench

//   N-requester bus arbiter; parametrised successor of the single-requester one-hot bus FSM.

---
 rtl/bus_arb_pkg.sv | 27 ++
 rtl/bus_arb_rr_pick.sv | 37 +++
 rtl/bus_arb_rr.sv | 146 ++++++++++++++
 tb/tb_bus_arb_rr.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
//   Shared constants for the round-robin bus arbiter.
//   - State bit indices (IDLE/BBUSY/BWAIT/BFREE) of the 4-bit one-hot
//     state register.
//   - One-hot state encodings built from those indices.
//   - ST_RESET: the encoding the state register takes under reset.
// ---------------------------------------------------------------------------
package bus_arb_pkg;

  localparam int IDLE  = 0;
  localparam int BBUSY = 1;
  localparam int BWAIT = 2;
  localparam int BFREE = 3;

  localparam int ST_W = 4;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = state_t'(1 << IDLE);
  localparam state_t ST_BBUSY = state_t'(1 << BBUSY);
  localparam state_t ST_BWAIT = state_t'(1 << BWAIT);
  localparam state_t ST_BFREE = state_t'(1 << BFREE);

  localparam state_t ST_RESET = 4'b0001;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// bus_arb_rr_pick
//   Combinational round-robin winner selection.
//   The search starts one position above the last owner and wraps from
//   NREQ-1 back to 0, so the last owner is looked at last and wins only
//   when it is the sole requester.
// Ports
//   req   in  NREQ  request vector
//   last  in  IDXW  index of the previous owner
//   valid out 1     at least one request is pending
//   win   out IDXW  index of the winning requester (0 when !valid)
// ---------------------------------------------------------------------------
module bus_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic            valid,
  output logic [IDXW-1:0] win
);

  always_comb begin
    valid = 1'b0;
    win   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      // The offset runs to NREQ, so the last owner itself is checked last.
      int idx;
      idx = (int'(last) + i) % NREQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        win   = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arb_rr.sv
// ---------------------------------------------------------------------------
// bus_arb_rr
//   N-requester bus arbiter. A four-state one-hot controller
//   (IDLE/BBUSY/BWAIT/BFREE) grants the shared bus to one requester at a
//   time, picked round-robin, and holds the grant until that requester
//   signals done (extended by the slave through dly). Every ownership
//   change passes through one BFREE cycle with no grant (bus turnaround).
//
//   Build option: define ARB_TIMEOUT_EN to add a watchdog that forces the
//   bus free after TIMEOUT_CYC cycles in BBUSY+BWAIT and pulses timeout.
//   Without it no counter is built and timeout is tied low.
//
// Ports
//   clk     in  1     rising-edge clock
//   rst     in  1     asynchronous active-high reset
//   req     in  NREQ  level requests, one per master
//   done    in  1     current owner finished its transfer (BBUSY only)
//   dly     in  1     slave asks to hold the grant after done
//   gnt     out NREQ  one-hot grant, zero when nobody owns the bus
//   gnt_id  out IDXW  index of current/last owner
//   busy    out 1     controller is not in IDLE
//   timeout out 1     one-cycle pulse in a forced BFREE
//
// Handshake: a master holds req until it sees its gnt bit; gnt then stays
// up until the cycle after the edge that samples done (or until dly drops
// when the slave extends). gnt/gnt_id/busy come straight from flops, so a
// master may register them without a combinational loop through req.
// ---------------------------------------------------------------------------
module bus_arb_rr
  import bus_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int IDXW        = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  input  logic            dly,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);

  state_t          state, state_n;
  logic [IDXW-1:0] owner, owner_n;
  logic            pick_valid;
  logic [IDXW-1:0] pick_win;
  logic            in_grant;

  bus_arb_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .last  (owner),
    .valid (pick_valid),
    .win   (pick_win)
  );

  // Grant phases only count when the state is a legal one-hot code.
  assign in_grant = $onehot(state) && (state[BBUSY] || state[BWAIT]);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic          force_rel;
  logic          timeout_q;
`endif

  // Next-state / owner logic.
  always_comb begin
    state_n = state;
    owner_n = owner;
`ifdef ARB_TIMEOUT_EN
    force_rel = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_n = ST_BBUSY;
          owner_n = pick_win;
        end
      end
      ST_BBUSY: begin
        if (done) state_n = dly ? ST_BWAIT : ST_BFREE;
      end
      ST_BWAIT: begin
        if (!dly) state_n = ST_BFREE;
      end
      ST_BFREE: begin
        if (pick_valid) begin
          state_n = ST_BBUSY;
          owner_n = pick_win;
        end else begin
          state_n = ST_IDLE;
        end
      end
      // Any non-one-hot code (including all-zero) recovers to IDLE and
      // leaves the owner untouched.
      default: state_n = ST_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    // The watchdog overrides done/dly in the last allowed grant cycle.
    if (in_grant && (cnt == CW'(TIMEOUT_CYC - 1))) begin
      state_n   = ST_BFREE;
      force_rel = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
      owner <= IDXW'(NREQ - 1);
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Cleared on every entry to BBUSY, so the first BBUSY cycle sees 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_n == ST_BBUSY) && (state != ST_BBUSY)) cnt <= '0;
      else if (in_grant)                                cnt <= cnt + 1'b1;
      timeout_q <= force_rel;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Outputs are pure decodes of state/owner flops.
  assign gnt    = in_grant ? (NREQ'(1) << owner) : '0;
  assign gnt_id = owner;
  assign busy   = (state != ST_RESET);

endmodule

// File: tb/tb_bus_arb_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_arb_rr
//   Directed bench for bus_arb_rr (NREQ=4). Inputs change 1 time unit after
//   a rising edge; outputs are checked at that same point, away from the
//   next edge. Build with ARB_TIMEOUT_EN defined to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_bus_arb_rr;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic            done = 1'b0;
  logic            dly = 1'b0;
  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] gnt_id;
  logic            busy;
  logic            timeout;

  int vectors = 0;
  int miscompares = 0;

  bus_arb_rr #(
    .NREQ        (NREQ),
    .IDXW        (IDXW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .dly     (dly),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [NREQ-1:0] e_gnt,
                           input logic [IDXW-1:0] e_id, input logic e_busy,
                           input logic e_to);
    check({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    check({tag, ".gnt_id"},  32'(gnt_id),  32'(e_id));
    check({tag, ".busy"},    32'(busy),    32'(e_busy));
    check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int rr_exp[4];
    rr_exp = '{1, 2, 3, 0};

    // Reset values
    tick();
    check_out("reset", 4'b0000, 2'd3, 1'b0, 1'b0);
    rst = 1'b0;

    // 1: single request, release, back to IDLE
    req = 4'b0100;
    tick();
    check_out("t1_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000; done = 1'b1; dly = 1'b0;
    tick();
    check_out("t1_bfree", 4'b0000, 2'd2, 1'b1, 1'b0);
    done = 1'b0;
    tick();
    check_out("t1_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // 2: all requesting, rotation 0,1,2,3,0 with one idle-grant cycle between
    do_reset();
    req = 4'b1111;
    tick();
    check_out("t2_own0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      done = 1'b1;
      tick();
      check_out("t2_gap", 4'b0000, IDXW'(rr_exp[(k + 3) % 4]), 1'b1, 1'b0);
      done = 1'b0;
      tick();
      check_out("t2_own", 4'(1 << rr_exp[k]), IDXW'(rr_exp[k]), 1'b1, 1'b0);
    end
    req = 4'b0000; done = 1'b1;
    tick();
    check_out("t2_bfree", 4'b0000, 2'd0, 1'b1, 1'b0);
    done = 1'b0;
    tick();
    check_out("t2_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // 3: owner 1, slave holds grant for 3 BWAIT cycles
    req = 4'b0010;
    tick();
    check_out("t3_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000; done = 1'b1; dly = 1'b1;
    tick();
    check_out("t3_bwait1", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 1'b0;
    tick();
    check_out("t3_bwait2", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    check_out("t3_bwait3", 4'b0010, 2'd1, 1'b1, 1'b0);
    dly = 1'b0;
    tick();
    check_out("t3_bfree", 4'b0000, 2'd1, 1'b1, 1'b0);
    tick();
    check_out("t3_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // 4: owner 3 drops req mid-transfer, grant held, then wrap to 0
    req = 4'b1000;
    tick();
    check_out("t4_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0001;
    tick();
    check_out("t4_hold1", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    check_out("t4_hold2", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    check_out("t4_bfree", 4'b0000, 2'd3, 1'b1, 1'b0);
    done = 1'b0;
    tick();
    check_out("t4_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 5: reset asserted during BWAIT drops everything at once
    done = 1'b1; dly = 1'b1;
    tick();
    check_out("t5_bwait", 4'b0001, 2'd0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_out("t5_async_rst", 4'b0000, 2'd3, 1'b0, 1'b0);
    done = 1'b0; dly = 1'b0; req = 4'b0011;
    tick();
    rst = 1'b0;
    tick();
    check_out("t5_after", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 6: done never comes
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      tick();
      check_out("t6_held", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    req = 4'b0000;
    tick();
    check_out("t6_forced", 4'b0000, 2'd0, 1'b1, 1'b1);
    tick();
    check_out("t6_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_out("t6_held", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    req = 4'b0000; done = 1'b1;
    tick();
    check_out("t6_bfree", 4'b0000, 2'd0, 1'b1, 1'b0);
    done = 1'b0;
    tick();
    check_out("t6_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
